// File: rtl/tone_seq_pkg.sv
// Shared state type and default constants for tone_sequencer.
// TONE_SEQUENCER_GAP_EN adds the GAP articulation state to the enum.
package tone_seq_pkg;

  localparam int unsigned DefTickDiv = 100000;
  localparam int unsigned DefDepth   = 8;

`ifdef TONE_SEQUENCER_GAP_EN
  typedef enum logic [1:0] {StIdle, StPlay, StGap} state_e;
`else
  typedef enum logic [1:0] {StIdle, StPlay} state_e;
`endif

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with occupancy count; push ignored when full, pop ignored when empty.
// Combinational read of the head entry.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [WIDTH-1:0]         i_wdata,
  output logic [WIDTH-1:0]         o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_rdata = r_mem[r_rd_ptr];
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset; pointers define validity.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wdata;
  end

endmodule

// File: rtl/tone_sequencer.sv
// Note FIFO plus square-wave player driving a speaker pin.
// Define TONE_SEQUENCER_GAP_EN to insert a one-tick silent gap after every played note.
module tone_sequencer
  import tone_seq_pkg::*;
#(
  parameter int unsigned HP_W     = 15,
  parameter int unsigned DUR_W    = 16,
  parameter int unsigned TICK_DIV = DefTickDiv,
  parameter int unsigned DEPTH    = DefDepth
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [HP_W-1:0]          in_half_period,
  input  logic [DUR_W-1:0]         in_duration,
  input  logic                     enable,
  output logic                     out,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned TW      = $clog2(TICK_DIV);
  localparam logic [TW-1:0] TickMax = TW'(TICK_DIV - 1);

  logic                    w_full;
  logic                    w_empty;
  logic                    w_push;
  logic                    w_pop;
  logic [HP_W+DUR_W-1:0]   w_head;
  logic [HP_W-1:0]         w_head_hp;
  logic [DUR_W-1:0]        w_head_dur;
  logic                    w_tick_wrap;
  logic [DUR_W-1:0]        w_dur_inc;

  state_e                  r_state;
  logic [HP_W-1:0]         r_hp;
  logic [DUR_W-1:0]        r_dur;
  logic [HP_W-1:0]         r_phase_cnt;
  logic [TW-1:0]           r_tick_cnt;
  logic [DUR_W-1:0]        r_dur_cnt;
  logic                    r_wave;

  assign in_ready    = !w_full && !rst;
  assign w_push      = in_valid && in_ready;
  assign w_pop       = (r_state == StIdle) && enable && !w_empty;
  assign {w_head_hp, w_head_dur} = w_head;
  assign w_tick_wrap = (r_tick_cnt == TickMax);
  assign w_dur_inc   = r_dur_cnt + 1'b1;
  // Pausing silences the pin but keeps the wave phase for resume.
  assign out         = r_wave && enable;
  assign busy        = (r_state != StIdle) || !w_empty;

  sync_fifo #(
    .WIDTH (HP_W + DUR_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdata ({in_half_period, in_duration}),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (level)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= StIdle;
      r_hp        <= '0;
      r_dur       <= '0;
      r_phase_cnt <= '0;
      r_tick_cnt  <= '0;
      r_dur_cnt   <= '0;
      r_wave      <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          // Zero-duration entries are popped and dropped without leaving IDLE.
          if (w_pop && (w_head_dur != '0)) begin
            r_hp        <= w_head_hp;
            r_dur       <= w_head_dur;
            r_phase_cnt <= '0;
            r_tick_cnt  <= '0;
            r_dur_cnt   <= '0;
            r_wave      <= 1'b0;
            r_state     <= StPlay;
          end
        end
        StPlay: begin
          if (enable) begin
            if (r_phase_cnt == r_hp) begin
              r_phase_cnt <= '0;
              if (r_hp != '0) r_wave <= !r_wave;
            end else begin
              r_phase_cnt <= r_phase_cnt + 1'b1;
            end
            if (w_tick_wrap) begin
              r_tick_cnt <= '0;
              r_dur_cnt  <= w_dur_inc;
              if (w_dur_inc == r_dur) begin
                r_wave      <= 1'b0;
                r_phase_cnt <= '0;
`ifdef TONE_SEQUENCER_GAP_EN
                r_state     <= StGap;
`else
                r_state     <= StIdle;
`endif
              end
            end else begin
              r_tick_cnt <= r_tick_cnt + 1'b1;
            end
          end
        end
`ifdef TONE_SEQUENCER_GAP_EN
        StGap: begin
          // Prescaler is already zero on entry, so this lasts one full tick.
          if (enable) begin
            if (w_tick_wrap) begin
              r_tick_cnt <= '0;
              r_state    <= StIdle;
            end else begin
              r_tick_cnt <= r_tick_cnt + 1'b1;
            end
          end
        end
`endif
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule
